// File: rtl/baud_tick_gen_if.sv
// Bit-timing bus between the baud decoder / UART engines and baud_tick_gen.
// half_tick exists only when BAUD_HALF_TICK_EN is defined.
interface baud_tick_gen_if;
  logic [18:0] baud_rate;
  logic        enable;
  logic        restart;
  logic        tick;
  logic        busy;
`ifdef BAUD_HALF_TICK_EN
  logic        half_tick;
`endif

  modport master (
    output baud_rate, enable, restart,
`ifdef BAUD_HALF_TICK_EN
    input  half_tick,
`endif
    input  tick, busy
  );

  modport slave (
    input  baud_rate, enable, restart,
`ifdef BAUD_HALF_TICK_EN
    output half_tick,
`endif
    output tick, busy
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Free-running bit-period strobe generator; new periods are latched only at bit
// boundaries. Optional mid-bit strobe is built when BAUD_HALF_TICK_EN is defined.
//
// state | meaning
// IDLE  | counter parked at 0, period tracks the clamped baud_rate every clock
// RUN   | counting bit periods, strobing tick at each terminal count
module baud_tick_gen #(
  parameter int unsigned MIN_PERIOD = 2,
  parameter logic [18:0] RST_PERIOD = 19'd10_417
) (
  input logic            clk,
  input logic            rst,
  baud_tick_gen_if.slave bus
);

  localparam logic [18:0] MinP = 19'(MIN_PERIOD);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [18:0] cnt_q;
  logic [18:0] period_q;
  logic        tick_q;
  logic        busy_q;
  logic [18:0] eff_d;
  logic        term_d;

`ifdef BAUD_HALF_TICK_EN
  logic [18:0] half_q;
  logic        half_tick_q;
  logic        half_hit_d;

  assign half_hit_d    = (cnt_q == (half_q - 19'd1));
  assign bus.half_tick = half_tick_q;
`endif

  assign eff_d   = (bus.baud_rate < MinP) ? MinP : bus.baud_rate;
  // period_q >= MIN_PERIOD, so the subtraction cannot wrap
  assign term_d  = (cnt_q == (period_q - 19'd1));
  assign bus.tick = tick_q;
  assign bus.busy = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= RST_PERIOD;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BAUD_HALF_TICK_EN
      half_q      <= RST_PERIOD >> 1;
      half_tick_q <= 1'b0;
`endif
    end else begin
      tick_q      <= 1'b0;
`ifdef BAUD_HALF_TICK_EN
      half_tick_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          period_q <= eff_d;
`ifdef BAUD_HALF_TICK_EN
          half_q   <= eff_d >> 1;
`endif
          if (bus.enable) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.enable) begin
            // disable wins over restart and suppresses any strobe
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (bus.restart) begin
            cnt_q    <= '0;
            period_q <= eff_d;
`ifdef BAUD_HALF_TICK_EN
            half_q   <= eff_d >> 1;
`endif
          end else begin
`ifdef BAUD_HALF_TICK_EN
            if (half_hit_d) half_tick_q <= 1'b1;
`endif
            if (term_d) begin
              cnt_q    <= '0;
              tick_q   <= 1'b1;
              period_q <= eff_d;
`ifdef BAUD_HALF_TICK_EN
              half_q   <= eff_d >> 1;
`endif
            end else begin
              cnt_q <= cnt_q + 19'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Bit-timing generator that consumes the 19-bit `baud_rate` cycle count from the baud decoder and turns it into single-cycle bit-period strobes for the UART transmit and receive engines. It free-runs while enabled, and it latches a new period only at bit boundaries so that a baud change never produces a truncated bit. A restart input lets the receiver realign timing to a detected start-bit edge. An optional mid-bit strobe supports receiver centre sampling.

## Interface
- `MIN_PERIOD`, 2: smallest period in clock cycles. Any `baud_rate` below this value is clamped up to it.
- `RST_PERIOD`, 19'd10_417: value held in the period register after reset.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset. Asynchronous and active-low: `rst`=0 immediately forces the reset state.
- `baud_rate` input, 19 bits: requested bit period in clk cycles, driven by the baud decoder.
- `enable` input, 1 bit: high = run, low = idle.
- `restart` input, 1 bit: synchronous realign. Zeroes the counter and reloads the period.
- `tick` output, 1 bit: registered one-cycle strobe at the end of each bit period.
- `half_tick` output, 1 bit: registered one-cycle strobe at mid-bit. Present only with `BAUD_HALF_TICK_EN`.
- `busy` output, 1 bit: high while in RUN.

## Operation
- **Registers**
  - `state` ∈ {IDLE, RUN}.
  - `cnt[18:0]`.
  - `period[18:0]`.
  - `half[18:0]` = `period >> 1`.
- **Clamp:** `eff` = (`baud_rate` < `MIN_PERIOD`) ? `MIN_PERIOD` : `baud_rate`.
- **IDLE**
  - `cnt` holds at 0.
  - `tick` = 0, `half_tick` = 0.
  - `period` <= `eff` on every clock, so it tracks `baud_rate` continuously.
  - `enable`=1 → RUN, with `cnt` <= 0 and `period` <= `eff`.
- **RUN** (priority order)
  1. `enable`=0 → IDLE, `cnt` <= 0, no strobe. Takes precedence over `restart`.
  2. `restart`=1 → `cnt` <= 0, `period` <= `eff`, no `tick`, even if `cnt` is at terminal count that cycle.
  3. `cnt` == `period`-1 → `cnt` <= 0, `tick` <= 1, `period` <= `eff`. This is the only point where the period changes.
  4. Otherwise `cnt` <= `cnt`+1.
- **`half_tick`:** set to 1 when `cnt` == `half`-1, in RUN, with no `restart` and `enable`=1.
- **Arithmetic:** all compares are 19-bit unsigned. `period`-1 never underflows because `period` ≥ 2. `cnt` never exceeds `period`-1.
- **`baud_rate` changes mid-bit** are ignored until the next terminal count, `restart`, or entry from IDLE.
- **Reset:** `state`=IDLE, `cnt`=0, `period`=`RST_PERIOD`, `tick`=0, `half_tick`=0, `busy`=0. Reset mid-bit aborts the bit and emits no strobe.

## Timing
- Call the edge at which `enable`=1 is sampled in IDLE edge E0.
- `tick` is first high in the cycle following edge E0+`period`. Afterwards it repeats every `period` cycles exactly, high for 1 cycle each time.
- `half_tick` is high in the cycle following edge E0+`half`. From period to period it keeps the same phase offset relative to `tick`.
- `restart` sampled at edge R: the next `tick` follows edge R+`eff`, and the next `half_tick` follows edge R+(`eff`>>1).
- `busy` goes high in the cycle after E0. It goes low in the cycle after the edge at which `enable`=0 is sampled.
- A new `baud_rate` applied mid-bit: the current bit completes at the old period, and the next bit uses the new one.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- **`BAUD_HALF_TICK_EN` defined:**
  - the `half` register, its compare logic, and the `half_tick` port are all present.
  - `half_tick` behaves as described under Operation.
- **Not defined:**
  - the `half_tick` port is absent from the port list.
  - the `half` register and its compare logic are not built.
  - the `tick`, `busy` and `restart` behaviour is unchanged.

## Test plan
- **Reset and enable:** release `rst`, `baud_rate`=868, `enable`=1. Required: `tick` pulses follow edges E0+868, E0+1736, and so on, each 1 cycle wide. With the macro defined, `half_tick` follows edges E0+434, E0+1302.
- **Mid-bit baud change:** `baud_rate`=217 in RUN; at `cnt`=100 change it to 109. Required: the current bit still ends 217 cycles after its start, and the following ticks are spaced 109 cycles apart.
- **Restart at terminal count:** assert `restart` at `cnt`=216 with period 217. Required: no `tick` that cycle, and the next `tick` follows 217 edges later.
- **Enable drop with restart:** in RUN, drive `enable`=0 and `restart`=1 together. Required: IDLE, `busy`=0, no strobes, `cnt`=0.
- **Clamp:** `baud_rate`=0, then `baud_rate`=1. Required: `tick` every 2 cycles in both cases, `half_tick` every 2 cycles offset by 1.
- **Async reset mid-bit:** pull `rst` low at `cnt`=5000 with period 10417, between clock edges. Required: immediately `busy`=0, `tick`=0, `period`=10417. After release and `enable`=1, the first `tick` follows edge E0+10417.
